// File: rtl/snake_pkg.sv
// Shared definitions for the snake display blocks: screen state encodings,
// RGB565 colour constants and a visible-area helper.
package snake_pkg;

  localparam logic [1:0] ST_TITLE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_WIN   = 2'd2;
  localparam logic [1:0] ST_LOSE  = 2'd3;

  localparam logic [15:0] RGB_BLACK = 16'h0000;

  function automatic logic in_display(
    input logic [10:0] xpos,
    input logic [10:0] ypos,
    input logic [10:0] h_disp,
    input logic [10:0] v_disp
  );
    in_display = (xpos < h_disp) && (ypos < v_disp);
  endfunction

endpackage

// File: rtl/snake_frame_timer.sv
// Frame-rate timing for the screen controller: start-of-frame tick,
// saturating end-screen hold counter and win-text blink generator.
module snake_frame_timer
  import snake_pkg::*;
#(
  parameter logic [7:0] HOLD_FRAMES  = 8'd120,
  parameter logic [5:0] BLINK_FRAMES = 6'd30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        hold_clr,
  input  logic        blink_clr,
  output logic        frame_tick,
  output logic        hold_done,
  output logic        blink_on
);

  logic       at_origin_s;
  logic       origin_q;
  logic       tick_q;
  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic [5:0] blink_cnt_q;
  logic [5:0] blink_cnt_d;
  logic       blink_on_q;
  logic       blink_on_d;

  assign at_origin_s = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);

  // A run of cycles parked at (0,0) yields only one tick: the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      origin_q <= at_origin_s;
      tick_q   <= at_origin_s & ~origin_q;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (hold_clr) begin
      hold_d = 8'd0;
    end else if (tick_q && (hold_q != HOLD_FRAMES)) begin
      hold_d = hold_q + 8'd1;
    end else begin
      hold_d = hold_q;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (blink_clr) begin
      blink_cnt_d = 6'd0;
      blink_on_d  = 1'b0;
    end else if (tick_q) begin
      if (blink_cnt_q == (BLINK_FRAMES - 6'd1)) begin
        blink_cnt_d = 6'd0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 6'd1;
        blink_on_d  = blink_on_q;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= 8'd0;
      blink_cnt_q <= 6'd0;
      blink_on_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign frame_tick = tick_q;
  assign hold_done  = (hold_q == HOLD_FRAMES);
  assign blink_on   = blink_on_q;

endmodule

// File: rtl/snake_screen_ctrl.sv
// Snake screen controller: title/play/win/lose state machine driven by key
// edges and game status, plus the registered output pixel selector.
module snake_screen_ctrl
  import snake_pkg::*;
#(
  parameter logic [7:0]  WIN_LEN      = 8'd30,
  parameter logic [7:0]  HOLD_FRAMES  = 8'd120,
  parameter logic [5:0]  BLINK_FRAMES = 6'd30,
  parameter logic [10:0] H_DISP       = 11'd640,
  parameter logic [10:0] V_DISP       = 11'd480
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        key_start,
  input  logic        key_back,
  input  logic        snake_dead,
  input  logic [7:0]  snake_len,
  input  logic [15:0] pixel_title,
  input  logic [15:0] pixel_game,
  input  logic [15:0] pixel_win,
  input  logic [15:0] pixel_lose,
  output logic [15:0] pixel_data,
  output logic        game_run,
  output logic        game_reset,
  output logic [1:0]  scr_state
);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        keys_armed_q;
  logic        key_start_q;
  logic        key_back_q;
  logic        start_edge_q;
  logic        back_edge_q;
  logic        game_run_q;
  logic        game_reset_q;
  logic [15:0] pixel_q;
  logic [15:0] pixel_d;
  logic        hold_clr_s;
  logic        blink_clr_s;
  logic        frame_tick_s;
  logic        hold_done_s;
  logic        blink_on_s;

  snake_frame_timer #(
    .HOLD_FRAMES  (HOLD_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk        (clk),
    .rst        (rstn),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .hold_clr   (hold_clr_s),
    .blink_clr  (blink_clr_s),
    .frame_tick (frame_tick_s),
    .hold_done  (hold_done_s),
    .blink_on   (blink_on_s)
  );

  // The armed flag suppresses a false edge from a key held through reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      keys_armed_q <= 1'b0;
      key_start_q  <= 1'b0;
      key_back_q   <= 1'b0;
      start_edge_q <= 1'b0;
      back_edge_q  <= 1'b0;
    end else begin
      keys_armed_q <= 1'b1;
      key_start_q  <= key_start;
      key_back_q   <= key_back;
      start_edge_q <= keys_armed_q & key_start & ~key_start_q;
      back_edge_q  <= keys_armed_q & key_back & ~key_back_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TITLE: begin
        if (start_edge_q) state_d = ST_PLAY;
        else              state_d = state_q;
      end
      ST_PLAY: begin
        if (snake_dead)                state_d = ST_LOSE;
        else if (snake_len >= WIN_LEN) state_d = ST_WIN;
        else                           state_d = state_q;
      end
      ST_WIN, ST_LOSE: begin
        // Edge pulses last one cycle, so presses during the hold just vanish.
        if (hold_done_s && start_edge_q)     state_d = ST_PLAY;
        else if (hold_done_s && back_edge_q) state_d = ST_TITLE;
        else                                 state_d = state_q;
      end
      default: state_d = ST_TITLE;
    endcase
  end

  assign hold_clr_s  = (state_q == ST_PLAY) &&
                       ((state_d == ST_WIN) || (state_d == ST_LOSE));
  assign blink_clr_s = (state_q == ST_PLAY) && (state_d == ST_WIN);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q      <= ST_TITLE;
      game_run_q   <= 1'b0;
      game_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_run_q   <= (state_d == ST_PLAY);
      game_reset_q <= (state_d == ST_PLAY) && (state_q != ST_PLAY);
    end
  end

  always_comb begin
    pixel_d = RGB_BLACK;
    if (!in_display(pixel_xpos, pixel_ypos, H_DISP, V_DISP)) begin
      pixel_d = RGB_BLACK;
    end else begin
      case (state_q)
        ST_TITLE: pixel_d = pixel_title;
        ST_PLAY:  pixel_d = pixel_game;
        ST_WIN:   pixel_d = blink_on_s ? pixel_win : pixel_game;
        ST_LOSE:  pixel_d = (pixel_lose != RGB_BLACK) ? pixel_lose : pixel_game;
        default:  pixel_d = RGB_BLACK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pixel_q <= RGB_BLACK;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign pixel_data = pixel_q;
  assign game_run   = game_run_q;
  assign game_reset = game_reset_q;
  assign scr_state  = state_q;

endmodule

// File: tb/tb_snake_screen_ctrl.sv
// Directed self-checking bench for snake_screen_ctrl.
module tb_snake_screen_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        key_start;
  logic        key_back;
  logic        snake_dead;
  logic [7:0]  snake_len;
  logic [15:0] pixel_title;
  logic [15:0] pixel_game;
  logic [15:0] pixel_win;
  logic [15:0] pixel_lose;
  logic [15:0] pixel_data;
  logic        game_run;
  logic        game_reset;
  logic [1:0]  scr_state;

  int n_checks = 0;
  int n_errors = 0;

  snake_screen_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .key_start   (key_start),
    .key_back    (key_back),
    .snake_dead  (snake_dead),
    .snake_len   (snake_len),
    .pixel_title (pixel_title),
    .pixel_game  (pixel_game),
    .pixel_win   (pixel_win),
    .pixel_lose  (pixel_lose),
    .pixel_data  (pixel_data),
    .game_run    (game_run),
    .game_reset  (game_reset),
    .scr_state   (scr_state)
  );

  always #5 clk = ~clk;

  // One frame: a single cycle at the origin, then three cycles elsewhere.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      pixel_xpos = 11'd0;
      pixel_ypos = 11'd0;
      @(negedge clk);
      pixel_xpos = 11'd1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd0 || pixel_data !== 16'h0000 || game_run !== 1'b0 || game_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: state=%0d pix=%h run=%b rst=%b required 0/0000/0/0",
               scr_state, pixel_data, game_run, game_reset);
    end
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd0 || game_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL key_held_through_reset: state=%0d rst=%b required 0/0", scr_state, game_reset);
    end
    key_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    key_start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd0) begin
      n_errors++;
      $display("FAIL start_latency1: state=%0d required 0", scr_state);
    end
    @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd1 || game_reset !== 1'b1 || game_run !== 1'b1) begin
      n_errors++;
      $display("FAIL start_enter_play: state=%0d rst=%b run=%b required 1/1/1",
               scr_state, game_reset, game_run);
    end
    @(negedge clk);
    n_checks++;
    if (game_reset !== 1'b0 || game_run !== 1'b1) begin
      n_errors++;
      $display("FAIL start_pulse_width: rst=%b run=%b required 0/1", game_reset, game_run);
    end
    key_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_play_keys();
    key_back = 1'b1;
    repeat (3) @(negedge clk);
    key_start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd1 || game_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL play_keys_ignored: state=%0d rst=%b required 1/0", scr_state, game_reset);
    end
    key_back  = 1'b0;
    key_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pixel_bounds();
    logic [10:0] xs [4] = '{11'd5, 11'd640, 11'd10, 11'd639};
    logic [10:0] ys [4] = '{11'd5, 11'd10, 11'd480, 11'd479};
    logic [15:0] ex [4] = '{16'h1234, 16'h0000, 16'h0000, 16'h1234};
    pixel_game = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      pixel_xpos = xs[i];
      pixel_ypos = ys[i];
      @(negedge clk);
      n_checks++;
      if (pixel_data !== ex[i]) begin
        n_errors++;
        $display("FAIL pixel_bounds[%0d]: x=%0d y=%0d pix=%h required %h",
                 i, xs[i], ys[i], pixel_data, ex[i]);
      end
    end
  endtask

  task automatic test_dead_priority();
    pixel_xpos = 11'd5;
    pixel_ypos = 11'd5;
    snake_len  = 8'd30;
    snake_dead = 1'b1;
    @(negedge clk);
    snake_dead = 1'b0;
    snake_len  = 8'd3;
    n_checks++;
    if (scr_state !== 2'd3 || game_run !== 1'b0) begin
      n_errors++;
      $display("FAIL dead_priority: state=%0d run=%b required 3/0", scr_state, game_run);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd3) begin
      n_errors++;
      $display("FAIL dead_stays_lose: state=%0d required 3", scr_state);
    end
  endtask

  task automatic test_lose_hold();
    int pulses;
    pixel_game = 16'h1234;
    pixel_lose = 16'h0000;
    @(negedge clk);
    n_checks++;
    if (pixel_data !== 16'h1234) begin
      n_errors++;
      $display("FAIL lose_transparent: pix=%h required 1234", pixel_data);
    end
    pixel_lose = 16'hF800;
    @(negedge clk);
    n_checks++;
    if (pixel_data !== 16'hF800) begin
      n_errors++;
      $display("FAIL lose_text: pix=%h required f800", pixel_data);
    end
    frames(50);
    key_start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd3 || game_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL lose_early_start: state=%0d rst=%b required 3/0", scr_state, game_reset);
    end
    key_start = 1'b0;
    @(negedge clk);
    frames(75);
    n_checks++;
    if (scr_state !== 2'd3) begin
      n_errors++;
      $display("FAIL lose_no_queued_edge: state=%0d required 3", scr_state);
    end
    key_start = 1'b1;
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (game_reset === 1'b1) pulses++;
    end
    n_checks++;
    if (scr_state !== 2'd1 || pulses != 1) begin
      n_errors++;
      $display("FAIL lose_restart: state=%0d pulses=%0d required 1/1", scr_state, pulses);
    end
    key_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_win_blink();
    pixel_win  = 16'h5555;
    pixel_game = 16'h0000;
    pixel_xpos = 11'd5;
    pixel_ypos = 11'd5;
    snake_len  = 8'd30;
    @(negedge clk);
    snake_len = 8'd3;
    n_checks++;
    if (scr_state !== 2'd2) begin
      n_errors++;
      $display("FAIL win_entry: state=%0d required 2", scr_state);
    end
    @(negedge clk);
    n_checks++;
    if (pixel_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL win_first_phase: pix=%h required 0000", pixel_data);
    end
    frames(28);
    // Parking at the origin for five cycles must count as a single frame.
    pixel_xpos = 11'd0;
    pixel_ypos = 11'd0;
    repeat (5) @(negedge clk);
    pixel_xpos = 11'd1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pixel_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL origin_single_tick: pix=%h required 0000", pixel_data);
    end
    frames(1);
    n_checks++;
    if (pixel_data !== 16'h5555) begin
      n_errors++;
      $display("FAIL blink_on_30: pix=%h required 5555", pixel_data);
    end
    frames(29);
    n_checks++;
    if (pixel_data !== 16'h5555) begin
      n_errors++;
      $display("FAIL blink_hold_59: pix=%h required 5555", pixel_data);
    end
    frames(1);
    n_checks++;
    if (pixel_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL blink_off_60: pix=%h required 0000", pixel_data);
    end
    key_back = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd2) begin
      n_errors++;
      $display("FAIL win_early_back: state=%0d required 2", scr_state);
    end
    key_back = 1'b0;
    @(negedge clk);
    frames(65);
    key_start = 1'b1;
    key_back  = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd1 || game_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL win_both_keys: state=%0d rst=%b required 1/1", scr_state, game_reset);
    end
    key_start = 1'b0;
    key_back  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lose_back();
    snake_dead = 1'b1;
    @(negedge clk);
    snake_dead = 1'b0;
    frames(125);
    key_back = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd0 || game_run !== 1'b0) begin
      n_errors++;
      $display("FAIL lose_back_title: state=%0d run=%b required 0/0", scr_state, game_run);
    end
    pixel_title = 16'hABCD;
    pixel_xpos  = 11'd5;
    pixel_ypos  = 11'd5;
    key_back    = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pixel_data !== 16'hABCD) begin
      n_errors++;
      $display("FAIL title_pixel: pix=%h required abcd", pixel_data);
    end
    key_back = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (scr_state !== 2'd0) begin
      n_errors++;
      $display("FAIL title_back_ignored: state=%0d required 0", scr_state);
    end
    key_back = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    key_start = 1'b1;
    repeat (3) @(negedge clk);
    key_start = 1'b0;
    n_checks++;
    if (scr_state !== 2'd1) begin
      n_errors++;
      $display("FAIL mid_enter_play: state=%0d required 1", scr_state);
    end
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (game_reset === 1'b1) pulses++;
    end
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (game_reset === 1'b1) pulses++;
    end
    n_checks++;
    if (scr_state !== 2'd0 || pulses != 0 || game_run !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_abandon: state=%0d pulses=%0d run=%b required 0/0/0",
               scr_state, pulses, game_run);
    end
  endtask

  initial begin
    rstn        = 1'b1;
    pixel_xpos  = 11'd5;
    pixel_ypos  = 11'd5;
    key_start   = 1'b1;
    key_back    = 1'b0;
    snake_dead  = 1'b0;
    snake_len   = 8'd3;
    pixel_title = 16'h0000;
    pixel_game  = 16'h0000;
    pixel_win   = 16'h0000;
    pixel_lose  = 16'h0000;
    test_reset();
    test_start();
    test_play_keys();
    test_pixel_bounds();
    test_dead_priority();
    test_lose_hold();
    test_win_blink();
    test_lose_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_screen_ctrl.md
SNAKE_SCREEN_CTRL -- requirements
Module: snake_screen_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIN_LEN  8'd30  snake length that ends a round as a win
  HOLD_FRAMES  8'd120  frames a WIN/LOSE screen ignores keys
  BLINK_FRAMES  6'd30  frames per blink half-period of the win text
  H_DISP  11'd640  visible width in pixels
  V_DISP  11'd480  visible height in pixels
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  VGA drive clock
  rstn  in  1  reset, asynchronous, active-high (1 = reset)
  pixel_xpos  in  11  current pixel column
  pixel_ypos  in  11  current pixel row
  key_start  in  1  debounced start/restart key level
  key_back  in  1  debounced back-to-title key level
  snake_dead  in  1  one-cycle pulse when the snake collides
  snake_len  in  8  current snake length
  pixel_title  in  16  RGB565 title-layer pixel
  pixel_game  in  16  RGB565 playfield pixel
  pixel_win  in  16  RGB565 win-text pixel
  pixel_lose  in  16  RGB565 lose-text pixel
  pixel_data  out  16  selected RGB565 pixel to VGA driver
  game_run  out  1  high while state is PLAY
  game_reset  out  1  one-cycle pulse clearing the game datapath
  scr_state  out  2  current state encoding

Function
REQ-003 FSM states SHALL be TITLE=2'd0, PLAY=2'd1, WIN=2'd2, LOSE=2'd3; scr_state SHALL equal the state register.
REQ-004 frame_tick SHALL be a one-cycle pulse in the cycle after (pixel_xpos,pixel_ypos) first becomes (0,0); consecutive cycles at (0,0) SHALL produce one tick.
REQ-005 start_edge/back_edge SHALL be rising edges of key_start/key_back, detected from one registered sample (1-cycle detection latency).
REQ-006 TITLE: start_edge -> PLAY; key_back ignored.
REQ-007 PLAY: snake_dead -> LOSE; else snake_len >= WIN_LEN -> WIN; snake_dead SHALL take priority when both occur in the same cycle; keys ignored in PLAY.
REQ-008 Entry into WIN or LOSE SHALL clear an 8-bit hold counter, incremented per frame_tick and saturating at HOLD_FRAMES.
REQ-009 WIN/LOSE: with hold counter == HOLD_FRAMES, start_edge -> PLAY, else back_edge -> IDLE-equivalent TITLE; start_edge SHALL win if both edges coincide; edges before hold expiry SHALL be discarded, not queued.
REQ-010 game_reset SHALL pulse high for exactly one cycle, in the cycle the state register becomes PLAY.
REQ-011 game_run SHALL be registered and equal (next state == PLAY), so it is high in the same cycle as game_reset.
REQ-012 Blink: 6-bit frame counter and blink_on flag, both cleared on WIN entry; counter increments per frame_tick; on reaching BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
REQ-013 pixel_data SHALL be registered with 1-cycle latency from the pixel inputs: TITLE->pixel_title, PLAY->pixel_game, WIN->(blink_on ? pixel_win : pixel_game), LOSE->(pixel_lose != 16'h0000 ? pixel_lose : pixel_game).
REQ-014 pixel_data SHALL be 16'h0000 whenever pixel_xpos >= H_DISP or pixel_ypos >= V_DISP, regardless of state.

Reset
REQ-015 While rstn=1: state=TITLE, pixel_data=16'h0000, game_run=0, game_reset=0, hold and blink counters=0, blink_on=0, key edge registers=0.
REQ-016 A key held high through reset release SHALL NOT generate an edge; reset asserted mid-round SHALL abandon the round without a game_reset pulse.

Structure
REQ-017 State encodings and RGB565 constants (black 16'h0000) SHALL live in a shared snake package used by all snake display blocks.
REQ-018 One sub-module, snake_frame_timer (frame_tick, hold counter, blink counter), SHALL be instantiated; FSM and pixel mux remain in the top.

Verification
REQ-019 Reset, then start_edge -> scr_state=1 two cycles after key rise, game_reset high exactly 1 cycle, game_run=1.
REQ-020 In PLAY, snake_dead pulse with snake_len=30 in same cycle -> scr_state=3 (LOSE), never 2.
REQ-021 In LOSE, start_edge at frame 50 -> no change; start_edge after 120 frame_ticks -> PLAY with one game_reset pulse.
REQ-022 In WIN with pixel_win=16'h5555, pixel_game=16'h0000 -> pixel_data alternates 16'h5555/16'h0000 every 30 frames, starting with 16'h0000 at entry.
REQ-023 Any state, pixel_xpos=640, pixel_ypos=10 -> pixel_data=16'h0000 one cycle later; (x,y) held at (0,0) for 5 cycles -> one frame_tick.
